// File: rtl/mult_div.sv
// Multi-cycle multiply/divide unit with HI/LO registers for a MIPS-style pipeline.
// The result is computed at launch, held in tmp_hi/tmp_lo, and committed after a fixed latency.
module mult_div (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, next_state;
    logic [3:0]  cnt;
    logic [31:0] tmp_hi, tmp_lo;

    logic        launch, finish;
    logic        div_zero, div_ovf;
    logic [31:0] b_safe;
    logic signed [63:0] a_ext, b_ext;
    logic [63:0] prod_s, prod_u, res;
    logic [31:0] q_s, r_s, q_u, r_u;

    // valid/ready: start is a one-cycle request accepted only when busy is low;
    // a start seen while busy is dropped, not queued.
    always_comb begin
        launch     = 1'b0;
        finish     = 1'b0;
        next_state = state;
        case (state)
            IDLE: begin
                launch = start;
                if (start) next_state = RUN;
            end
            RUN: begin
                finish = (cnt == 4'd1);
                if (cnt == 4'd1) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Divider sees a harmless divisor in the cases whose result is fixed by rule.
    always_comb begin
        div_zero = (B == 32'd0);
        div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
        b_safe   = (div_zero || div_ovf) ? 32'd1 : B;
        a_ext    = {{32{A[31]}}, A};
        b_ext    = {{32{B[31]}}, B};
        prod_s   = a_ext * b_ext;
        prod_u   = {32'd0, A} * {32'd0, B};
        q_s      = $signed(A) / $signed(b_safe);
        r_s      = $signed(A) % $signed(b_safe);
        q_u      = A / b_safe;
        r_u      = A % b_safe;
        res      = prod_s;
        case (op)
            2'b00: res = prod_s;
            2'b01: res = prod_u;
            2'b10: begin
                if (div_zero)     res = {HI, LO};
                else if (div_ovf) res = {32'd0, 32'h8000_0000};
                else              res = {r_s, q_s};
            end
            2'b11: res = div_zero ? {HI, LO} : {r_u, q_u};
            default: res = prod_s;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Divide-by-zero reloads the current HI/LO into tmp so the commit leaves them unchanged.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt    <= 4'd0;
            busy   <= 1'b0;
            HI     <= 32'd0;
            LO     <= 32'd0;
            tmp_hi <= 32'd0;
            tmp_lo <= 32'd0;
        end else begin
            busy <= (next_state == RUN);
            if (launch) begin
                tmp_hi <= res[63:32];
                tmp_lo <= res[31:0];
                cnt    <= op[1] ? 4'd10 : 4'd5;
            end else if (state == RUN) begin
                cnt <= cnt - 4'd1;
                if (finish) begin
                    HI <= tmp_hi;
                    LO <= tmp_lo;
                end
            end else begin
                if (mthi) HI <= A;
                if (mtlo) LO <= A;
            end
        end
    end

endmodule

// File: tb/tb_mult_div.sv
// Directed bench for mult_div: latency, signed/unsigned results, corner cases,
// ignored requests while busy, reset mid-operation and HI/LO moves.
module tb_mult_div;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A, B;
    logic        mthi, mtlo;
    logic        busy;
    logic [31:0] HI, LO;

    int n_checks = 0;
    int n_errors = 0;

    mult_div dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launches one operation, scrambles the operands afterwards, checks the busy
    // window length and the committed HI/LO in the first non-busy cycle.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int nb,
                          input logic [31:0] ehi, input logic [31:0] elo);
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        step();
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        for (int i = 0; i < nb; i++) begin
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            step();
        end
        check({tag, "_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_hi"}, HI, ehi);
        check({tag, "_lo"}, LO, elo);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        A     = 32'd0;
        B     = 32'd0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        step();
        step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        reset = 1'b1;
        step();

        // Back-to-back: each run_op starts in the first idle cycle of the previous one.
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_zero", 2'b11, 32'd7, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
        run_op("div_negb", 2'b10, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu", 2'b11, 32'd100, 32'd7, 10, 32'd2, 32'd14);
        run_op("div_zero", 2'b10, 32'hFFFF_FFF9, 32'd0, 10, 32'd2, 32'd14);
        run_op("mult_mix", 2'b00, 32'h0001_0000, 32'hFFFF_0000, 5, 32'hFFFF_FFFF, 32'h0000_0000);

        // Requests during a divide are ignored: 100 / -7 = -14 rem 2.
        op    = 2'b10;
        A     = 32'd100;
        B     = 32'hFFFF_FFF9;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        op    = 2'b00;
        start = 1'b1;
        mthi  = 1'b1;
        A     = 32'h1234_5678;
        B     = 32'd5;
        step();
        check("ign_hi_mid", HI, 32'hFFFF_FFFF);
        step();
        start = 1'b0;
        mthi  = 1'b0;
        for (int i = 5; i <= 10; i++) begin
            check("ign_busy", {31'd0, busy}, 32'd1);
            step();
        end
        check("ign_done", {31'd0, busy}, 32'd0);
        check("ign_hi", HI, 32'd2);
        check("ign_lo", LO, 32'hFFFF_FFF2);
        step();
        check("ign_no_relaunch", {31'd0, busy}, 32'd0);

        // Reset mid-multiply discards it; moves during reset are ignored.
        op    = 2'b00;
        A     = 32'd3;
        B     = 32'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b0;
        mthi  = 1'b1;
        A     = 32'h0000_0055;
        step();
        check("rmid_busy", {31'd0, busy}, 32'd0);
        check("rmid_hi", HI, 32'd0);
        check("rmid_lo", LO, 32'd0);
        reset = 1'b1;
        mthi  = 1'b0;
        mtlo  = 1'b1;
        A     = 32'hCAFE_F00D;
        step();
        mtlo  = 1'b0;
        check("mtlo_lo", LO, 32'hCAFE_F00D);
        check("mtlo_hi", HI, 32'd0);
        check("mtlo_busy", {31'd0, busy}, 32'd0);
        mthi  = 1'b1;
        mtlo  = 1'b1;
        A     = 32'h1111_1111;
        step();
        mthi  = 1'b0;
        mtlo  = 1'b0;
        check("mvboth_hi", HI, 32'h1111_1111);
        check("mvboth_lo", LO, 32'h1111_1111);
        for (int i = 0; i < 6; i++) step();
        check("stale_hi", HI, 32'h1111_1111);
        check("stale_lo", LO, 32'h1111_1111);

        // start wins over a simultaneous move.
        op    = 2'b01;
        A     = 32'd2;
        B     = 32'd3;
        mthi  = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        mthi  = 1'b0;
        check("prio_hi_mid", HI, 32'h1111_1111);
        for (int i = 1; i <= 5; i++) begin
            check("prio_busy", {31'd0, busy}, 32'd1);
            step();
        end
        check("prio_done", {31'd0, busy}, 32'd0);
        check("prio_hi", HI, 32'd0);
        check("prio_lo", LO, 32'd6);
        run_op("b2b_mult", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'd0, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
